// File: rtl/vga_sprite_fetch_if.sv
// rtl/vga_sprite_fetch_if.sv - CPU request and data-memory port bundle for the sprite fetcher
interface vga_sprite_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: grants the CPU and drives the single memory port.
  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata, mem_rdata,
    output cpu_gnt, mem_addr, mem_we, mem_wdata
  );

  // Environment side: CPU requests in, memory read data back.
  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_wdata, mem_rdata,
    input  cpu_gnt, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_sprite_fetch.sv
// rtl/vga_sprite_fetch.sv - per-frame sprite coordinate fetch sharing the CPU memory port
module vga_sprite_fetch #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h3F00,
  parameter int                MEM_LAT    = 1,
  parameter int                STARVE_MAX = 4
) (
  input  logic                     clk_50m,
  input  logic                     btn_rst_n,
  input  logic                     frame,
  vga_sprite_fetch_if.slave        bus,
  output logic signed [DATA_W-1:0] mx,
  output logic signed [DATA_W-1:0] my,
  output logic signed [DATA_W-1:0] p1x,
  output logic signed [DATA_W-1:0] p1y,
  output logic signed [DATA_W-1:0] p2x,
  output logic signed [DATA_W-1:0] p2y,
  output logic                     coords_valid,
  output logic                     busy,
  output logic                     overrun
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_COMMIT} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] LAT_LOAD   = 2'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic              frame_prev_q;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        starve_q, starve_d;
  logic [1:0]        lat_q, lat_d;
  logic [DATA_W-1:0] shadow_q [6];
  logic [DATA_W-1:0] shadow_d [6];
  logic [DATA_W-1:0] coord_q  [6];
  logic [DATA_W-1:0] coord_d  [6];
  logic              valid_q, valid_d;
  logic              frame_edge;
  logic              issue;

  assign frame_edge = frame & ~frame_prev_q;

  // The fetch takes the port only when the CPU is quiet or has starved us long enough.
  assign issue = (state_q == S_REQ) && (!bus.cpu_req || (starve_q == STARVE_LIM));

  assign bus.cpu_gnt   = bus.cpu_req & ~issue;
  assign bus.mem_addr  = issue ? (BASE_ADDR + ADDR_W'(idx_q)) : bus.cpu_addr;
  assign bus.mem_we    = bus.cpu_we & bus.cpu_gnt;
  assign bus.mem_wdata = bus.cpu_wdata;

  assign busy         = (state_q != S_IDLE);
  assign overrun      = frame_edge & busy;
  assign coords_valid = valid_q;

  assign mx  = coord_q[0];
  assign my  = coord_q[1];
  assign p1x = coord_q[2];
  assign p1y = coord_q[3];
  assign p2x = coord_q[4];
  assign p2y = coord_q[5];

  // Next-state: walk six words through REQ/WAIT, then publish them all at once.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    starve_d = starve_q;
    lat_d    = lat_q;
    shadow_d = shadow_q;
    coord_d  = coord_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_edge) begin
          state_d = S_REQ;
          idx_d   = 3'd0;
        end
      end
      S_REQ: begin
        if (issue) begin
          starve_d = 4'd0;
          lat_d    = LAT_LOAD;
          state_d  = S_WAIT;
        end else if (starve_q != STARVE_LIM) begin
          starve_d = starve_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (lat_q == 2'd0) begin
          shadow_d[idx_q] = bus.mem_rdata;
          if (idx_q == 3'd5) begin
            state_d = S_COMMIT;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_REQ;
          end
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_COMMIT: begin
        coord_d = shadow_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, shadow and committed coordinates; reset drops any in-flight read.
  always_ff @(posedge clk_50m or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      state_q      <= S_IDLE;
      frame_prev_q <= 1'b0;
      idx_q        <= 3'd0;
      starve_q     <= 4'd0;
      lat_q        <= 2'd0;
      valid_q      <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= '0;
        coord_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame;
      idx_q        <= idx_d;
      starve_q     <= starve_d;
      lat_q        <= lat_d;
      valid_q      <= valid_d;
      shadow_q     <= shadow_d;
      coord_q      <= coord_d;
    end
  end

endmodule

// File: tb/tb_vga_sprite_fetch.sv
// tb/tb_vga_sprite_fetch.sv - randomized self-checking bench for vga_sprite_fetch
module tb_vga_sprite_fetch;
  localparam int          AW     = 16;
  localparam int          DW     = 16;
  localparam int          LAT    = 1;
  localparam int          SMAX   = 4;
  localparam logic [15:0] BASE   = 16'h3F00;
  localparam logic [15:0] BASE_W = 16'hFFFE;

  logic clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  logic btn_rst_n;
  logic frame;

  vga_sprite_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  vga_sprite_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus_w ();

  logic signed [DW-1:0] mx, my, p1x, p1y, p2x, p2y;
  logic signed [DW-1:0] wmx, wmy, wp1x, wp1y, wp2x, wp2y;
  logic coords_valid, busy, overrun;
  logic w_valid, w_busy, w_overrun;

  vga_sprite_fetch #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk_50m(clk_50m), .btn_rst_n(btn_rst_n), .frame(frame), .bus(bus),
    .mx(mx), .my(my), .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y),
    .coords_valid(coords_valid), .busy(busy), .overrun(overrun)
  );

  vga_sprite_fetch #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE_W), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut_w (
    .clk_50m(clk_50m), .btn_rst_n(btn_rst_n), .frame(frame), .bus(bus_w),
    .mx(wmx), .my(wmy), .p1x(wp1x), .p1y(wp1y), .p2x(wp2x), .p2y(wp2y),
    .coords_valid(w_valid), .busy(w_busy), .overrun(w_overrun)
  );

  logic [DW-1:0] got   [6];
  logic [DW-1:0] got_w [6];
  assign got[0] = mx;   assign got[1] = my;   assign got[2] = p1x;
  assign got[3] = p1y;  assign got[4] = p2x;  assign got[5] = p2y;
  assign got_w[0] = wmx;  assign got_w[1] = wmy;  assign got_w[2] = wp1x;
  assign got_w[3] = wp1y; assign got_w[4] = wp2x; assign got_w[5] = wp2y;

  // Memory model: one-cycle read latency, CPU writes plus a bench-only preload port.
  logic [DW-1:0] mem [0:65535];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] rd_q, rdw_q;

  always @(posedge clk_50m) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (ld_en) mem[ld_addr] <= ld_data;
    rd_q  <= mem[bus.mem_addr];
    rdw_q <= mem[bus_w.mem_addr];
  end

  assign bus.mem_rdata     = rd_q;
  assign bus_w.mem_rdata   = rdw_q;
  assign bus_w.cpu_req     = 1'b0;
  assign bus_w.cpu_addr    = '0;
  assign bus_w.cpu_we      = 1'b0;
  assign bus_w.cpu_wdata   = '0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] tbl [6];
  logic [DW-1:0] exp_coord [6];
  int            req_pat [64];
  int            issue_t [6];
  int            commit_vis;

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic load_table(input logic [15:0] base);
    for (int k = 0; k < 6; k++) begin
      ld_en   = 1'b1;
      ld_addr = base + 16'(k);
      ld_data = tbl[k];
      step();
    end
    ld_en = 1'b0;
    step();
  endtask

  // Schedule from the arbitration rules: each word waits while the CPU asks, at most SMAX cycles.
  function automatic void model_schedule();
    int t;
    int lost;
    t = 1;
    for (int k = 0; k < 6; k++) begin
      lost = 0;
      while (req_pat[t] != 0 && lost < SMAX) begin
        t++;
        lost++;
      end
      issue_t[k] = t;
      t = t + 1 + LAT;
    end
    commit_vis = issue_t[5] + LAT + 2;
  endfunction

  task automatic test_reset();
    btn_rst_n = 1'b0;
    frame = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_we = 1'b0; bus.cpu_wdata = '0;
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got[k] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_coord%0d got %h want 0000", k, got[k]);
      end
      exp_coord[k] = 16'h0000;
    end
    checks++;
    if (coords_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got valid=%b busy=%b overrun=%b want 0 0 0", coords_valid, busy, overrun);
    end
    @(posedge clk_50m);
    #1 btn_rst_n = 1'b1;
    step();
  endtask

  // mode 0: quiet CPU, 1: CPU requests every cycle, 2: random CPU traffic.
  task automatic test_arbitration(input int mode, input int frames);
    logic          exp_issue;
    logic          exp_gnt;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] exp_addr;
    int            kk;
    for (int f = 0; f < frames; f++) begin
      for (int k = 0; k < 6; k++) tbl[k] = (mode == 0) ? 16'((k + 1) * 16) : 16'($urandom);
      load_table(BASE);
      for (int c = 0; c < 64; c++) req_pat[c] = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 1)) : 0;
      model_schedule();
      for (int c = 0; c <= commit_vis + 1; c++) begin
        step();
        frame         = (c < 3);
        cur_addr      = AW'($urandom_range(0, 16'h0FFF));
        bus.cpu_req   = (req_pat[c] != 0);
        bus.cpu_addr  = cur_addr;
        bus.cpu_we    = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.cpu_wdata = 16'($urandom);
        @(negedge clk_50m);
        exp_issue = 1'b0;
        kk = 0;
        for (int k = 0; k < 6; k++) if (issue_t[k] == c) begin exp_issue = 1'b1; kk = k; end
        exp_gnt  = (req_pat[c] != 0) && !exp_issue;
        exp_addr = exp_issue ? (BASE + 16'(kk)) : cur_addr;
        checks++;
        if (bus.cpu_gnt !== exp_gnt) begin
          errors++;
          $display("FAIL arb%0d_gnt cycle %0d got %b want %b", mode, c, bus.cpu_gnt, exp_gnt);
        end
        checks++;
        if (bus.mem_addr !== exp_addr) begin
          errors++;
          $display("FAIL arb%0d_addr cycle %0d got %h want %h", mode, c, bus.mem_addr, exp_addr);
        end
        checks++;
        if (bus.mem_we !== (exp_gnt & bus.cpu_we)) begin
          errors++;
          $display("FAIL arb%0d_we cycle %0d got %b want %b", mode, c, bus.mem_we, exp_gnt & bus.cpu_we);
        end
        checks++;
        if (coords_valid !== (c == commit_vis)) begin
          errors++;
          $display("FAIL arb%0d_valid cycle %0d got %b want %b", mode, c, coords_valid, c == commit_vis);
        end
        checks++;
        if (busy !== (c >= 1 && c < commit_vis)) begin
          errors++;
          $display("FAIL arb%0d_busy cycle %0d got %b want %b", mode, c, busy, (c >= 1 && c < commit_vis));
        end
        if (c == commit_vis - 1 || c == commit_vis) begin
          if (c == commit_vis) for (int k = 0; k < 6; k++) exp_coord[k] = tbl[k];
          for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== exp_coord[k]) begin
              errors++;
              $display("FAIL arb%0d_coord%0d cycle %0d got %h want %h", mode, k, c, got[k], exp_coord[k]);
            end
          end
        end
      end
      frame = 1'b0;
      bus.cpu_req = 1'b0;
      bus.cpu_we = 1'b0;
      step();
    end
  endtask

  task automatic test_cpu_write_wait();
    for (int k = 0; k < 6; k++) tbl[k] = 16'((k + 1) * 16);
    load_table(BASE);
    for (int c = 0; c <= 14; c++) begin
      step();
      frame         = (c < 3);
      bus.cpu_req   = (c == 2);
      bus.cpu_we    = (c == 2);
      bus.cpu_addr  = 16'h3F01;
      bus.cpu_wdata = 16'hABCD;
      @(negedge clk_50m);
      if (c == 2) begin
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin
          errors++;
          $display("FAIL wr_wait_grant got gnt=%b we=%b want 1 1", bus.cpu_gnt, bus.mem_we);
        end
      end
    end
    tbl[1] = 16'hABCD;
    checks++;
    if (coords_valid !== 1'b1) begin
      errors++;
      $display("FAIL wr_wait_valid got %b want 1", coords_valid);
    end
    for (int k = 0; k < 6; k++) begin
      exp_coord[k] = tbl[k];
      checks++;
      if (got[k] !== tbl[k]) begin
        errors++;
        $display("FAIL wr_wait_coord%0d got %h want %h", k, got[k], tbl[k]);
      end
    end
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; frame = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    for (int k = 0; k < 6; k++) tbl[k] = 16'($urandom);
    load_table(BASE);
    for (int c = 0; c <= 20; c++) begin
      step();
      frame = (c < 3) || (c >= 6);
      @(negedge clk_50m);
      checks++;
      if (overrun !== (c == 6)) begin
        errors++;
        $display("FAIL ovr_pulse cycle %0d got %b want %b", c, overrun, c == 6);
      end
      checks++;
      if (coords_valid !== (c == 14) || busy !== (c >= 1 && c <= 13)) begin
        errors++;
        $display("FAIL ovr_single_fetch cycle %0d got valid=%b busy=%b want %b %b", c, coords_valid, busy, c == 14, (c >= 1 && c <= 13));
      end
      if (c == 14) begin
        for (int k = 0; k < 6; k++) begin
          exp_coord[k] = tbl[k];
          checks++;
          if (got[k] !== tbl[k]) begin
            errors++;
            $display("FAIL ovr_coord%0d got %h want %h", k, got[k], tbl[k]);
          end
        end
      end
    end
    frame = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_fetch();
    for (int k = 0; k < 6; k++) tbl[k] = 16'($urandom) | 16'h0001;
    load_table(BASE);
    for (int c = 0; c <= 5; c++) begin
      step();
      frame = (c < 3);
    end
    btn_rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || coords_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags got busy=%b valid=%b overrun=%b want 0 0 0", busy, coords_valid, overrun);
    end
    for (int k = 0; k < 6; k++) begin
      exp_coord[k] = 16'h0000;
      checks++;
      if (got[k] !== 16'h0000) begin
        errors++;
        $display("FAIL midrst_coord%0d got %h want 0000", k, got[k]);
      end
    end
    step();
    step();
    btn_rst_n = 1'b1;
    step();
    for (int c = 0; c <= 14; c++) begin
      step();
      frame = (c < 3);
      @(negedge clk_50m);
    end
    checks++;
    if (coords_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_refetch_valid got %b want 1", coords_valid);
    end
    for (int k = 0; k < 6; k++) begin
      exp_coord[k] = tbl[k];
      checks++;
      if (got[k] !== tbl[k]) begin
        errors++;
        $display("FAIL midrst_refetch_coord%0d got %h want %h", k, got[k], tbl[k]);
      end
    end
    frame = 1'b0;
    step();
  endtask

  task automatic test_address_wrap();
    logic [15:0] want;
    for (int k = 0; k < 6; k++) tbl[k] = 16'($urandom);
    load_table(BASE_W);
    for (int c = 0; c <= 14; c++) begin
      step();
      frame = (c < 3);
      @(negedge clk_50m);
      for (int k = 0; k < 6; k++) begin
        if (c == 1 + 2 * k) begin
          want = BASE_W + 16'(k);
          checks++;
          if (bus_w.mem_addr !== want) begin
            errors++;
            $display("FAIL wrap_addr%0d got %h want %h", k, bus_w.mem_addr, want);
          end
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got_w[k] !== tbl[k]) begin
        errors++;
        $display("FAIL wrap_coord%0d got %h want %h", k, got_w[k], tbl[k]);
      end
    end
    frame = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_arbitration(0, 1);
    test_arbitration(1, 1);
    test_arbitration(2, 8);
    test_cpu_write_wait();
    test_overrun();
    test_reset_mid_fetch();
    test_address_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
